frame_sequencer: RTL and testbench

FRAME_SEQUENCER -- requirements
Module: frame_sequencer

---
 rtl/frame_sequencer_pkg.sv | 17 +
 rtl/frame_sequencer_fb_clear_counter.sv | 23 ++
 rtl/frame_sequencer.sv | 111 +++++++++++
 tb/tb_frame_sequencer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/frame_sequencer_pkg.sv
// frame_sequencer_pkg: shared state encoding, framebuffer geometry defaults and clear constants
// for the frame sequencer, rasterizer and AXI wrapper.
package frame_sequencer_pkg;
    localparam int          FB_WORDS_DEF    = 76800;
    localparam int          ADDR_W_DEF      = 17;
    localparam logic [7:0]  CLEAR_COLOR_DEF = 8'h00;
    localparam logic [15:0] CLEAR_Z_DEF     = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_WAIT_TRI,
        ST_ISSUE,
        ST_RASTER,
        ST_WAIT_VS,
        ST_SWAP
    } state_t;
endpackage

// File: rtl/frame_sequencer_fb_clear_counter.sv
// fb_clear_counter: back-buffer clear address generator; wraps to 0 on its last word
// so the next clear always begins at address 0.
module fb_clear_counter #(
    parameter int FB_WORDS = 76800,
    parameter int ADDR_W   = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic [ADDR_W-1:0] addr,
    output logic              start,
    output logic              done
);
    assign start = en & (addr == '0);
    assign done  = en & (addr == ADDR_W'(FB_WORDS - 1));

    always_ff @(posedge clk) begin
        if (rst)
            addr <= '0;
        else if (en)
            addr <= done ? '0 : addr + 1'b1;
    end
endmodule

// File: rtl/frame_sequencer.sv
// frame_sequencer: clears the back buffer, feeds triangles one at a time to the rasterizer,
// then waits for a committed frame and a vsync falling edge before swapping buffers.
module frame_sequencer
    import frame_sequencer_pkg::*;
#(
    parameter int          FB_WORDS    = FB_WORDS_DEF,
    parameter int          ADDR_W      = ADDR_W_DEF,
    parameter logic [7:0]  CLEAR_COLOR = CLEAR_COLOR_DEF,
    parameter logic [15:0] CLEAR_Z     = CLEAR_Z_DEF
) (
    input  logic              axi_aclk,
    input  logic              axi_reset,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    output logic              triangle_valid,
    input  logic              triangle_ready,
    input  logic              rasterizer_done,
    input  logic              frame_commit,
    input  logic              vsync,
    input  logic              gpu_we,
    input  logic [ADDR_W-1:0] gpu_addr,
    input  logic [7:0]        gpu_color,
    input  logic [15:0]       gpu_z,
    output logic              fb_we,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [7:0]        fb_color,
    output logic [15:0]       fb_z,
    output logic              front_sel,
    output logic [15:0]       frame_count,
    output logic              busy
);
    state_t            state, state_nx;
    logic              commit_pending, commit_clr, vs_prev;
    logic              clr_start, clr_done;
    logic [ADDR_W-1:0] clr_addr;

    fb_clear_counter #(.FB_WORDS(FB_WORDS), .ADDR_W(ADDR_W)) u_clr (
        .clk   (axi_aclk),
        .rst   (axi_reset),
        .en    (state == ST_CLEAR),
        .addr  (clr_addr),
        .start (clr_start),
        .done  (clr_done)
    );

    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            state          <= ST_CLEAR;
            commit_pending <= 1'b0;
            front_sel      <= 1'b0;
            frame_count    <= '0;
            vs_prev        <= 1'b1;
        end else begin
            state          <= state_nx;
            commit_pending <= frame_commit | (commit_pending & ~commit_clr);
            vs_prev        <= vsync;
            if (state == ST_SWAP) begin
                front_sel   <= ~front_sel;
                frame_count <= frame_count + 16'd1;
            end
        end
    end

    always_comb begin
        state_nx       = state;
        fifo_rd_en     = 1'b0;
        triangle_valid = 1'b0;
        commit_clr     = 1'b0;
        fb_we          = gpu_we;
        fb_addr        = gpu_addr;
        fb_color       = gpu_color;
        fb_z           = gpu_z;
        case (state)
            ST_CLEAR: begin
                fb_we    = 1'b1;
                fb_addr  = clr_addr;
                fb_color = CLEAR_COLOR;
                fb_z     = CLEAR_Z;
                state_nx = clr_done ? ST_WAIT_TRI : ST_CLEAR;
            end
            ST_WAIT_TRI: begin
                // a queued triangle outranks a pending commit
                if (!fifo_empty) begin
                    fifo_rd_en = 1'b1;
                    state_nx   = ST_ISSUE;
                end else if (commit_pending) begin
                    commit_clr = 1'b1;
                    state_nx   = ST_WAIT_VS;
                end
            end
            ST_ISSUE: begin
                triangle_valid = 1'b1;
                state_nx       = triangle_ready ? ST_RASTER : ST_ISSUE;
            end
            ST_RASTER:  state_nx = rasterizer_done ? ST_WAIT_TRI : ST_RASTER;
            ST_WAIT_VS: state_nx = (vs_prev & ~vsync) ? ST_SWAP : ST_WAIT_VS;
            ST_SWAP:    state_nx = ST_CLEAR;
            default:    state_nx = ST_CLEAR;
        endcase
        if (axi_reset) begin
            fifo_rd_en     = 1'b0;
            triangle_valid = 1'b0;
            fb_we          = 1'b0;
        end
    end

    assign busy = (state != ST_WAIT_TRI);

    a_swap_restarts_clear: assert property (@(posedge axi_aclk) disable iff (axi_reset)
        (state == ST_SWAP) |=> clr_start);
endmodule

// File: tb/tb_frame_sequencer.sv
// tb_frame_sequencer: directed check of clear, triangle handshake, commit/vsync swap,
// gpu pass-through arbitration and mid-operation reset with a 16-word framebuffer.
module tb_frame_sequencer;
    localparam int FBW = 16;
    localparam int AW  = 17;

    logic          clk = 1'b0;
    logic          axi_reset, fifo_empty, fifo_rd_en, triangle_valid, triangle_ready;
    logic          rasterizer_done, frame_commit, vsync, gpu_we, fb_we, front_sel, busy;
    logic [AW-1:0] gpu_addr, fb_addr;
    logic [7:0]    gpu_color, fb_color;
    logic [15:0]   gpu_z, fb_z, frame_count;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [7:0]    color;
        logic [15:0]   z;
        logic          exp_we;
        logic [AW-1:0] exp_addr;
        logic [7:0]    exp_color;
        logic [15:0]   exp_z;
    } vec_t;
    vec_t tbl [4];

    frame_sequencer #(.FB_WORDS(FBW), .ADDR_W(AW)) dut (
        .axi_aclk        (clk),
        .axi_reset       (axi_reset),
        .fifo_empty      (fifo_empty),
        .fifo_rd_en      (fifo_rd_en),
        .triangle_valid  (triangle_valid),
        .triangle_ready  (triangle_ready),
        .rasterizer_done (rasterizer_done),
        .frame_commit    (frame_commit),
        .vsync           (vsync),
        .gpu_we          (gpu_we),
        .gpu_addr        (gpu_addr),
        .gpu_color       (gpu_color),
        .gpu_z           (gpu_z),
        .fb_we           (fb_we),
        .fb_addr         (fb_addr),
        .fb_color        (fb_color),
        .fb_z            (fb_z),
        .front_sel       (front_sel),
        .frame_count     (frame_count),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Called just after a negedge in the first CLEAR cycle; returns at the first WAIT_TRI negedge.
    task automatic run_clear(input bit inject_gpu);
        for (int i = 0; i < FBW; i++) begin
            if (inject_gpu && i == 5) begin
                gpu_we = 1'b1; gpu_addr = 17'd5; gpu_color = 8'hAB; gpu_z = 16'h1234;
            end else begin
                gpu_we = 1'b0; gpu_addr = '0; gpu_color = '0; gpu_z = '0;
            end
            #1;
            chk("clr_we", fb_we, 1'b1);
            chk("clr_addr", fb_addr, i);
            chk("clr_color", fb_color, 8'h00);
            chk("clr_z", fb_z, 16'hFFFF);
            @(negedge clk);
        end
        gpu_we = 1'b0; gpu_addr = '0; gpu_color = '0; gpu_z = '0;
        #1;
        chk("clr_end_busy", busy, 1'b0);
        chk("clr_end_we", fb_we, 1'b0);
    endtask

    initial begin
        tbl[0] = '{1'b1, 17'd5,       8'hAB, 16'h1234, 1'b1, 17'd5,       8'hAB, 16'h1234};
        tbl[1] = '{1'b0, 17'd7,       8'h3C, 16'h0042, 1'b0, 17'd7,       8'h3C, 16'h0042};
        tbl[2] = '{1'b1, 17'h1FFFF,   8'hFF, 16'h0000, 1'b1, 17'h1FFFF,   8'hFF, 16'h0000};
        tbl[3] = '{1'b1, 17'd0,       8'h12, 16'h8000, 1'b1, 17'd0,       8'h12, 16'h8000};

        axi_reset = 1'b1; fifo_empty = 1'b1; triangle_ready = 1'b0; rasterizer_done = 1'b0;
        frame_commit = 1'b0; vsync = 1'b1;
        gpu_we = 1'b0; gpu_addr = '0; gpu_color = '0; gpu_z = '0;
        @(negedge clk); @(negedge clk);
        gpu_we = 1'b1;
        #1;
        chk("rst_fb_we", fb_we, 1'b0);
        chk("rst_valid", triangle_valid, 1'b0);
        chk("rst_rd_en", fifo_rd_en, 1'b0);
        chk("rst_front", front_sel, 1'b0);
        chk("rst_count", frame_count, 16'd0);
        chk("rst_busy", busy, 1'b1);
        gpu_we = 1'b0;
        axi_reset = 1'b0;
        run_clear(1'b1);

        rasterizer_done = 1'b1;
        @(negedge clk);
        rasterizer_done = 1'b0;
        #1 chk("done_ignored_busy", busy, 1'b0);

        // triangle 1 with a 3-cycle ready stall
        fifo_empty = 1'b0;
        #1;
        chk("t1_rd_en", fifo_rd_en, 1'b1);
        chk("t1_valid_early", triangle_valid, 1'b0);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t1_stall_valid", triangle_valid, 1'b1);
            chk("t1_stall_rd_en", fifo_rd_en, 1'b0);
            @(negedge clk);
        end
        triangle_ready = 1'b1;
        #1 chk("t1_accept_valid", triangle_valid, 1'b1);
        @(negedge clk);
        triangle_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            gpu_we = tbl[i].we; gpu_addr = tbl[i].addr; gpu_color = tbl[i].color; gpu_z = tbl[i].z;
            #1;
            chk("pass_we", fb_we, tbl[i].exp_we);
            chk("pass_addr", fb_addr, tbl[i].exp_addr);
            chk("pass_color", fb_color, tbl[i].exp_color);
            chk("pass_z", fb_z, tbl[i].exp_z);
            chk("raster_rd_en", fifo_rd_en, 1'b0);
            chk("raster_valid", triangle_valid, 1'b0);
            @(negedge clk);
        end
        gpu_we = 1'b0; gpu_addr = '0; gpu_color = '0; gpu_z = '0;
        rasterizer_done = 1'b1;
        #1 chk("t1_done_rd_en", fifo_rd_en, 1'b0);
        @(negedge clk);
        rasterizer_done = 1'b0;

        // triangle 2, commit arrives while it rasterizes
        #1 chk("t2_rd_en", fifo_rd_en, 1'b1);
        @(negedge clk);
        fifo_empty = 1'b1; triangle_ready = 1'b1;
        #1 chk("t2_valid", triangle_valid, 1'b1);
        @(negedge clk);
        triangle_ready = 1'b0; frame_commit = 1'b1;
        #1 chk("t2_raster_busy", busy, 1'b1);
        @(negedge clk);
        frame_commit = 1'b0;
        #1 chk("t2_commit_held_busy", busy, 1'b1);
        @(negedge clk);
        rasterizer_done = 1'b1;
        @(negedge clk);
        rasterizer_done = 1'b0;
        #1;
        chk("t2_wait_tri_busy", busy, 1'b0);
        chk("t2_wait_tri_rd_en", fifo_rd_en, 1'b0);
        @(negedge clk);
        #1 chk("wait_vs_busy", busy, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1 chk("wait_vs_front", front_sel, 1'b0);
        end
        vsync = 1'b0;
        @(negedge clk);
        #1;
        chk("swap_front_old", front_sel, 1'b0);
        chk("swap_count_old", frame_count, 16'd0);
        @(negedge clk);
        #1;
        chk("swap1_front", front_sel, 1'b1);
        chk("swap1_count", frame_count, 16'd1);
        run_clear(1'b0);

        // reset during RASTER
        fifo_empty = 1'b0;
        @(negedge clk);
        fifo_empty = 1'b1; triangle_ready = 1'b1;
        @(negedge clk);
        triangle_ready = 1'b0;
        #1;
        chk("r_raster_busy", busy, 1'b1);
        chk("r_raster_valid", triangle_valid, 1'b0);
        gpu_we = 1'b1; axi_reset = 1'b1;
        #1 chk("r_reset_fb_we", fb_we, 1'b0);
        @(negedge clk);
        #1;
        chk("r_after_valid", triangle_valid, 1'b0);
        chk("r_after_front", front_sel, 1'b0);
        chk("r_after_count", frame_count, 16'd0);
        chk("r_after_fb_we", fb_we, 1'b0);
        gpu_we = 1'b0; axi_reset = 1'b0;
        run_clear(1'b0);

        // commit with vsync already low: swap needs a fresh falling edge
        frame_commit = 1'b1;
        @(negedge clk);
        frame_commit = 1'b0;
        #1 chk("lowvs_wait_tri", busy, 1'b0);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("lowvs_busy", busy, 1'b1);
            chk("lowvs_front", front_sel, 1'b0);
            @(negedge clk);
        end
        vsync = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1 chk("lowvs_high_front", front_sel, 1'b0);
        vsync = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("swap2_front", front_sel, 1'b1);
        chk("swap2_count", frame_count, 16'd1);
        run_clear(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
